dff_rs: RTL and testbench



---
 rtl/dff_rs.sv | 32 +++
 tb/tb_dff_rs.sv | 126 ++++++++++++
 2 files changed

// File: rtl/dff_rs.sv
`timescale 1ns/1ps
// dff_rs: single-bit rising-edge D flip-flop with asynchronous active-low
// reset and asynchronous active-low set. Reset has priority over set.
// This is the leaf storage cell that registers and counters are built from.
//
// Ports:
//   clk      clock; d is sampled on the rising edge
//   reset_n  asynchronous active-low reset, forces q to 0 (highest priority)
//   set_n    asynchronous active-low set, forces q to 1
//   d        data input
//   q        registered data output
module dff_rs (
    input  logic clk,
    input  logic reset_n,
    input  logic set_n,
    input  logic d,
    output logic q
);

    // Test reset first, then set. The level of whichever input is still
    // asserted is re-evaluated on every event, so both-low resolves to 0.
    always_ff @(posedge clk or negedge reset_n or negedge set_n) begin
        if (!reset_n) begin
            q <= 1'b0;
        end else if (!set_n) begin
            q <= 1'b1;
        end else begin
            q <= d;
        end
    end

endmodule

// File: tb/tb_dff_rs.sv
`timescale 1ns/1ps
// tb_dff_rs: directed-vector bench for dff_rs. The clock has a 10 ns period
// with rising edges at 5, 15, 25 ns and so on. Stimulus is placed at absolute
// times. q is sampled 1 ns or more away from any rising edge, and every
// expected value below is worked out by hand from the flip-flop's priority
// rules.
module tb_dff_rs;

    logic clk;
    logic reset_n;
    logic set_n;
    logic d;
    logic q;

    int unsigned total;
    int unsigned bad;

    dff_rs dut (
        .clk     (clk),
        .reset_n (reset_n),
        .set_n   (set_n),
        .d       (d),
        .q       (q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts the check and reports any mismatch.
    task automatic check_bit(input string tag, input logic got, input logic exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s @%0t: q=%b expected=%b", tag, $time, got, exp);
        end
    endtask

    // Advance to an absolute simulation time in ns.
    task automatic at_ns(input int unsigned t);
        if (64'(t) > $time) #(64'(t) - $time);
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        reset_n = 1'b1;
        set_n   = 1'b1;
        d       = 1'b1;

        // 1: both async inputs low, d toggling -> q held at 0
        at_ns(1);   reset_n = 1'b0; set_n = 1'b0;
        at_ns(3);   check_bit("both_low_t3", q, 1'b0);
        at_ns(6);   check_bit("both_low_t6", q, 1'b0);
        at_ns(10);  d = 1'b0;
        at_ns(16);  check_bit("both_low_t16", q, 1'b0);
        at_ns(20);  d = 1'b1;
        at_ns(26);  check_bit("both_low_t26", q, 1'b0);
        at_ns(30);  d = 1'b0;
        at_ns(36);  check_bit("both_low_t36", q, 1'b0);

        // 2: reset released with set still low -> q=1 regardless of d
        at_ns(40);  reset_n = 1'b1; d = 1'b1;
        at_ns(46);  check_bit("set_only_t46", q, 1'b1);
        at_ns(50);  d = 1'b0;
        at_ns(56);  check_bit("set_only_t56", q, 1'b1);
        at_ns(60);  d = 1'b1;
        at_ns(66);  check_bit("set_only_t66", q, 1'b1);
        at_ns(70);  d = 1'b0;
        at_ns(76);  check_bit("set_only_t76", q, 1'b1);

        // 3: normal clocking, q follows d one edge later
        at_ns(80);  set_n = 1'b1; d = 1'b1;
        at_ns(82);  check_bit("set_release_hold", q, 1'b1);
        at_ns(86);  check_bit("clk_t85_d1", q, 1'b1);
        at_ns(90);  d = 1'b0;
        at_ns(96);  check_bit("clk_t95_d0", q, 1'b0);
        at_ns(100); d = 1'b1;
        at_ns(106); check_bit("clk_t105_d1", q, 1'b1);
        at_ns(110); d = 1'b0;
        at_ns(116); check_bit("clk_t115_d0", q, 1'b0);

        // 4: mid-cycle reset pulse while q=1
        at_ns(120); d = 1'b1;
        at_ns(126); check_bit("pre_reset_q1", q, 1'b1);
        at_ns(128); reset_n = 1'b0;
        at_ns(129); check_bit("async_reset", q, 1'b0);
        at_ns(131); reset_n = 1'b1;
        at_ns(133); check_bit("reset_release_hold", q, 1'b0);
        at_ns(136); check_bit("reset_release_load", q, 1'b1);

        // 5: both low, set released first, then reset
        at_ns(138); reset_n = 1'b0; set_n = 1'b0;
        at_ns(139); check_bit("both_low_again", q, 1'b0);
        at_ns(141); set_n = 1'b1;
        at_ns(142); check_bit("set_rel_first", q, 1'b0);
        at_ns(146); check_bit("reset_over_clk", q, 1'b0);
        at_ns(148); reset_n = 1'b1;
        at_ns(149); check_bit("reset_rel_last", q, 1'b0);
        at_ns(156); check_bit("post_rel_load", q, 1'b1);

        // mid-cycle set pulse while q=0, then hold until edge
        at_ns(158); d = 1'b0;
        at_ns(166); check_bit("pre_set_q0", q, 1'b0);
        at_ns(168); set_n = 1'b0;
        at_ns(169); check_bit("async_set", q, 1'b1);
        at_ns(171); set_n = 1'b1;
        at_ns(173); check_bit("set_release_hold2", q, 1'b1);
        at_ns(176); check_bit("set_release_load", q, 1'b0);

        // 6: d glitches between edges do not reach q
        at_ns(177); d = 1'b1;
        at_ns(179); d = 1'b0;
        at_ns(180); check_bit("glitch_hi_ignored", q, 1'b0);
        at_ns(181); d = 1'b1;
        at_ns(184); check_bit("pre_edge_hold", q, 1'b0);
        at_ns(186); check_bit("edge_load_1", q, 1'b1);
        at_ns(188); d = 1'b0;
        at_ns(190); d = 1'b1;
        at_ns(192); check_bit("glitch_lo_ignored", q, 1'b1);
        at_ns(196); check_bit("edge_load_1b", q, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
